// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the existing receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Frame sequencing states shared by TX and RX.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    // 50 MHz core clock at 9600 baud.
    localparam int DEFAULT_N = 5208;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..N-1 while enabled and ticks on the last cycle of a bit.
// Latency: tick is combinational from the registered count; count updates every cycle.
// Backpressure: none; clr forces the count back to zero and has priority over en.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(N);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == CW'(N - 1));

    // Next count: clear wins, otherwise wrap at N-1 while enabled, hold when disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, LSB first, each bit held N clock cycles.
// Latency: tx drops on the edge that accepts start; done pulses 10*N cycles later.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
module uart_tx
    import uart_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    uart_state_e          state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 baud_en;
    logic                 baud_clr;
    logic                 baud_tick;

    // The counter only runs while a frame is in flight.
    assign baud_en = (state_q != IDLE);

    uart_baud_gen #(
        .N(N)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (baud_en),
        .clr  (baud_clr),
        .tick (baud_tick)
    );

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    // Next-state and registered-output logic; every state change also clears the baud counter.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        data_d   = data_q;
        idx_d    = idx_q;
        baud_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = START;
                    data_d   = data;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    idx_d    = '0;
                    baud_clr = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d  = DATA;
                    tx_d     = data_q[0];
                    idx_d    = '0;
                    baud_clr = 1'b1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d  = STOP;
                        tx_d     = 1'b1;
                        baud_clr = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = data_q[idx_q + IDX_W'(1)];
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    baud_clr = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                tx_d     = 1'b1;
                busy_d   = 1'b0;
                baud_clr = 1'b1;
            end
        endcase
    end

    // State and output registers; reset idles the line high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model plus serial decoder scoreboard.
// Latency: expected line state derived from cycles elapsed since each accepted start.
// Backpressure: model accepts start only once the previous frame's done cycle has passed.
module tb_uart_tx;

    localparam int N     = 10;
    localparam int FRAME = 10 * N;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       tx;
    logic       busy;
    logic       done;

    always #10 clk = ~clk;

    uart_tx #(
        .N(N)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    // Reference model: one frame = start bit, 8 data bits LSB first, stop bit, N cycles each.
    exp_t       sb_q[$];
    bit         act     = 1'b0;
    int         acc     = 0;
    int         n_acc   = 0;
    logic [7:0] mbyte   = 8'h00;
    logic       exp_tx  = 1'b1;
    logic       exp_bsy = 1'b0;
    logic       exp_dn  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            act     = 1'b0;
            sb_q.delete();
            exp_tx  = 1'b1;
            exp_bsy = 1'b0;
            exp_dn  = 1'b0;
        end else begin
            cyc++;
            if (start && (!act || cyc >= acc + FRAME + 1)) begin
                act   = 1'b1;
                acc   = cyc;
                mbyte = data;
                n_acc++;
                sb_q.push_back('{b: data, t: cyc + FRAME});
            end
            exp_tx  = 1'b1;
            exp_bsy = 1'b0;
            exp_dn  = 1'b0;
            if (act) begin
                int d;
                int j;
                d = cyc - acc;
                j = d / N;
                if (d < FRAME) begin
                    exp_bsy = 1'b1;
                    if (j == 0)      exp_tx = 1'b0;
                    else if (j <= 8) exp_tx = mbyte[j-1];
                end else if (d == FRAME) begin
                    exp_dn = 1'b1;
                end
            end
        end
    end

    // Monitor: per-cycle line checks, mid-bit serial decoding, and scoreboard pop on done.
    bit         rx_on   = 1'b0;
    int         rx_cnt  = 0;
    logic [7:0] rx_sr   = 8'h00;
    logic [7:0] rx_byte = 8'h00;
    exp_t       e;

    always @(negedge clk) begin
        if (!rst) begin
            rx_on  = 1'b0;
            rx_cnt = 0;
        end else begin
            check("tx_line", tx, exp_tx);
            check("busy", busy, exp_bsy);
            check("done", done, exp_dn);
            if (!rx_on) begin
                if (tx == 1'b0) begin
                    rx_on  = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_on && (rx_cnt % N == N / 2)) begin
                int b;
                b = rx_cnt / N;
                if (b == 0) begin
                    check("start_bit", tx, 0);
                end else if (b <= 8) begin
                    rx_sr[b-1] = tx;
                end else begin
                    check("stop_bit", tx, 1);
                    rx_byte = rx_sr;
                    rx_on   = 1'b0;
                end
            end
            if (done) begin
                check("sb_nonempty_at_done", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("rx_byte", rx_byte, e.b);
                    check("done_cycle", cyc, e.t);
                end
            end
        end
    end

    // Stimulus: reset, single frame with ignored starts, back-to-back, mid-frame reset, random loopback.
    initial begin
        int target;
        rst   = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Release and request on the very next edge; extra starts mid-frame must be ignored.
        rst   = 1'b1;
        start = 1'b1;
        data  = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        repeat (34) @(negedge clk);
        start = 1'b1;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (FRAME + 20) @(negedge clk);

        // Start held high: frames run back to back.
        start = 1'b1;
        data  = 8'h3C;
        repeat (3 * (FRAME + 1)) @(negedge clk);
        start = 1'b0;
        repeat (FRAME + 10) @(negedge clk);

        // Asynchronous reset while data bit 4 (a zero) is on the line.
        data  = 8'hC3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (54) @(negedge clk);
        @(posedge clk);
        #5 rst = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        data  = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (FRAME + 10) @(negedge clk);

        // Sixteen random bytes back to back; data churns every cycle.
        target = n_acc + 16;
        start  = 1'b1;
        for (int i = 0; i < 16 * (FRAME + 1) + 20 && n_acc < target; i++) begin
            data = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        check("loopback_count", n_acc, target);
        repeat (FRAME + 10) @(negedge clk);

        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
